// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - fetch/data arbiter sharing one single-port memory
// Outstanding owner IDs are queued so in-order responses route back to the right port.
module riscv_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          DATA_PRIO       = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        ireq_i,
    input  logic [31:0] iaddr_i,
    output logic        ignt_o,
    output logic        irvalid_o,
    output logic [31:0] irdata_o,

    input  logic        dreq_i,
    input  logic [31:0] daddr_i,
    input  logic        dwe_i,
    input  logic [3:0]  dbe_i,
    input  logic [31:0] dwdata_i,
    output logic        dgnt_o,
    output logic        drvalid_o,
    output logic [31:0] drdata_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;

    typedef enum logic {ARB, HOLD} state_e;

    state_e                     state_q, state_d;
    logic                       owner_q, owner_d;
    logic                       last_q, last_d;
    logic                       err_q, err_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;

    logic sel;
    logic sel_req;
    logic not_full;
    logic xfer;
    logic pop;
    logic stray;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // While a request is stalled in HOLD the selection is pinned to its owner.
    always_comb begin
        sel = ID_I;
        if (state_q == HOLD) begin
            sel = owner_q;
        end else if (ireq_i && dreq_i) begin
            sel = DATA_PRIO ? ID_D : ~last_q;
        end else if (dreq_i) begin
            sel = ID_D;
        end
    end

    always_comb begin
        sel_req     = (sel == ID_D) ? dreq_i : ireq_i;
        not_full    = (count_q < CNT_MAX);
        mem_req_o   = sel_req && not_full;
        xfer        = mem_req_o && mem_gnt_i;
        ignt_o      = xfer && (sel == ID_I);
        dgnt_o      = xfer && (sel == ID_D);

        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (sel_req) begin
            if (sel == ID_D) begin
                mem_addr_o  = daddr_i;
                mem_we_o    = dwe_i;
                mem_be_o    = dbe_i;
                mem_wdata_o = dwdata_i;
            end else begin
                mem_addr_o  = iaddr_i;
                mem_be_o    = 4'b1111;
            end
        end

        head      = ids_q[rd_ptr_q];
        pop       = mem_rvalid_i && (count_q != '0);
        stray     = mem_rvalid_i && (count_q == '0);
        irvalid_o = pop && (head == ID_I);
        drvalid_o = pop && (head == ID_D);
        irdata_o  = mem_rdata_i;
        drdata_o  = mem_rdata_i;
        err_o     = err_q;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        err_d    = err_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ids_d    = ids_q;

        case (state_q)
            ARB: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d = HOLD;
                    owner_d = sel;
                end
            end
            HOLD: begin
                // Owner withdrawing an ungranted request breaks the handshake.
                if (!sel_req) begin
                    state_d = ARB;
                    err_d   = 1'b1;
                end else if (xfer) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase

        if (xfer) begin
            last_d          = sel;
            ids_d[wr_ptr_q] = sel;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (stray) begin
            err_d = 1'b1;
        end

        case ({xfer, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB;
            owner_q  <= ID_I;
            last_q   <= ID_D;
            err_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ids_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            err_q    <= err_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ids_q    <= ids_d;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - scoreboard bench: round-robin and data-priority arbiters
module tb_riscv_mem_arbiter;

    logic clk;
    logic rst;

    logic [1:0]        ireq, ignt, irvalid;
    logic [1:0][31:0]  iaddr, irdata;
    logic [1:0]        dreq, dwe, dgnt, drvalid;
    logic [1:0][31:0]  daddr, dwdata, drdata;
    logic [1:0][3:0]   dbe, mem_be;
    logic [1:0]        mem_req, mem_we, mem_gnt, mem_rvalid, err;
    logic [1:0][31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [1:0]        force_rv;
    int                lat [2];

    int nchecks = 0;
    int nfail   = 0;
    logic [32:0] exp_q0 [$];
    logic [32:0] exp_q1 [$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_resp(input int k, input logic port, input logic [31:0] addr);
        if (k == 0) exp_q0.push_back({port, mem_data(addr)});
        else        exp_q1.push_back({port, mem_data(addr)});
    endtask

    task automatic mon(input int k);
        logic [32:0] e;
        logic        empty;
        if (irvalid[k] || drvalid[k]) begin
            check("rvalid_exclusive", 32'(irvalid[k] & drvalid[k]), 32'd0);
            empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty) begin
                nchecks++;
                nfail++;
                $display("FAIL unexpected_rvalid inst %0d: got a response, expected none", k);
            end else begin
                if (k == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                check("resp_port", 32'(drvalid[k]), 32'(e[32]));
                check("resp_data", drvalid[k] ? drdata[k] : irdata[k], e[31:0]);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_inst
        logic [7:0]  rv_pipe;
        logic [31:0] rd_pipe [8];

        riscv_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(k == 1)) u_dut (
            .clk_i(clk), .rst_i(rst),
            .ireq_i(ireq[k]), .iaddr_i(iaddr[k]), .ignt_o(ignt[k]),
            .irvalid_o(irvalid[k]), .irdata_o(irdata[k]),
            .dreq_i(dreq[k]), .daddr_i(daddr[k]), .dwe_i(dwe[k]), .dbe_i(dbe[k]),
            .dwdata_i(dwdata[k]), .dgnt_o(dgnt[k]), .drvalid_o(drvalid[k]), .drdata_o(drdata[k]),
            .mem_req_o(mem_req[k]), .mem_addr_o(mem_addr[k]), .mem_we_o(mem_we[k]),
            .mem_be_o(mem_be[k]), .mem_wdata_o(mem_wdata[k]), .mem_gnt_i(mem_gnt[k]),
            .mem_rvalid_i(mem_rvalid[k]), .mem_rdata_i(mem_rdata[k]), .err_o(err[k])
        );

        // Fixed-latency memory: an accepted request answers lat cycles later.
        always @(posedge clk) begin
            rv_pipe <= {1'b0, rv_pipe[7:1]};
            for (int i = 0; i < 7; i++) rd_pipe[i] <= rd_pipe[i+1];
            rd_pipe[7] <= '0;
            if (mem_req[k] && mem_gnt[k]) begin
                rv_pipe[lat[k]-1] <= 1'b1;
                rd_pipe[lat[k]-1] <= mem_data(mem_addr[k]);
            end
            if (rst) rv_pipe <= '0;
        end

        assign mem_rvalid[k] = rv_pipe[0] | force_rv[k];
        assign mem_rdata[k]  = force_rv[k] ? 32'hDEAD_BEEF : rd_pipe[0];
    end

    initial begin : stim
        logic [31:0] ia, da, dw;
        logic [1:0]  pat [10];
        logic        win [10];
        logic        p;
        logic        e;

        rst = 1'b1;
        ireq = '0; dreq = '0; dwe = '0; mem_gnt = '0; force_rv = '0;
        iaddr = '0; daddr = '0; dwdata = '0; dbe = '0;
        lat[0] = 1; lat[1] = 1;
        idle(3);
        rst = 1'b0;

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_mem_req", 32'(mem_req[k]), 32'd0);
            check("rst_ignt", 32'(ignt[k]), 32'd0);
            check("rst_dgnt", 32'(dgnt[k]), 32'd0);
            check("rst_irvalid", 32'(irvalid[k]), 32'd0);
            check("rst_drvalid", 32'(drvalid[k]), 32'd0);
            check("rst_err", 32'(err[k]), 32'd0);
            check("rst_mem_addr", mem_addr[k], 32'd0);
        end
        @(posedge clk); #1;

        // Round-robin tie, data port writing; first tie goes to fetch.
        ia = 32'h1000; da = 32'h2000; dw = 32'hCAFE_0000;
        mem_gnt[0] = 1'b1;
        ireq[0] = 1'b1; dreq[0] = 1'b1; dwe[0] = 1'b1; dbe[0] = 4'b0110;
        iaddr[0] = ia; daddr[0] = da; dwdata[0] = dw;
        for (int i = 0; i < 5; i++) begin
            p = i[0];
            @(negedge clk);
            check("rr_ignt", 32'(ignt[0]), 32'(!p));
            check("rr_dgnt", 32'(dgnt[0]), 32'(p));
            check("rr_addr", mem_addr[0], p ? da : ia);
            check("rr_we", 32'(mem_we[0]), 32'(p));
            check("rr_be", 32'(mem_be[0]), p ? 32'h6 : 32'hF);
            if (p) check("rr_wdata", mem_wdata[0], dw);
            expect_resp(0, p, p ? da : ia);
            @(posedge clk); #1;
            if (p) begin da = da + 4; dw = dw + 1; end
            else   ia = ia + 4;
            iaddr[0] = ia; daddr[0] = da; dwdata[0] = dw;
        end
        ireq[0] = 1'b0; dreq[0] = 1'b0; dwe[0] = 1'b0; dbe[0] = 4'hF;
        idle(2);

        // Fixed data priority on the second instance.
        ia = 32'h3000; da = 32'h4000;
        mem_gnt[1] = 1'b1;
        ireq[1] = 1'b1; dreq[1] = 1'b1; dbe[1] = 4'hF;
        iaddr[1] = ia; daddr[1] = da;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fp_dgnt", 32'(dgnt[1]), 32'd1);
            check("fp_ignt", 32'(ignt[1]), 32'd0);
            expect_resp(1, 1'b1, da);
            @(posedge clk); #1;
            da = da + 4; daddr[1] = da;
        end
        dreq[1] = 1'b0;
        @(negedge clk);
        check("fp_ignt_after_drop", 32'(ignt[1]), 32'd1);
        check("fp_addr_after_drop", mem_addr[1], ia);
        expect_resp(1, 1'b0, ia);
        @(posedge clk); #1;
        ireq[1] = 1'b0;
        idle(2);

        // HOLD: last grant was fetch, so a free tie would favour data.
        mem_gnt[0] = 1'b0;
        ireq[0] = 1'b1; iaddr[0] = 32'h100; daddr[0] = 32'h200;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) dreq[0] = 1'b1;
            if (c == 3) mem_gnt[0] = 1'b1;
            @(negedge clk);
            check("hold_req", 32'(mem_req[0]), 32'd1);
            check("hold_addr", mem_addr[0], 32'h100);
            check("hold_dgnt", 32'(dgnt[0]), 32'd0);
            check("hold_ignt", 32'(ignt[0]), 32'(c == 3));
            if (c == 3) expect_resp(0, 1'b0, 32'h100);
            @(posedge clk); #1;
        end
        ireq[0] = 1'b0;
        @(negedge clk);
        check("hold_next_dgnt", 32'(dgnt[0]), 32'd1);
        check("hold_next_addr", mem_addr[0], 32'h200);
        check("hold_next_we", 32'(mem_we[0]), 32'd0);
        expect_resp(0, 1'b1, 32'h200);
        @(posedge clk); #1;
        dreq[0] = 1'b0;
        idle(2);

        // Full FIFO with a 4-cycle memory.
        lat[0] = 4;
        ia = 32'h500; ireq[0] = 1'b1; iaddr[0] = ia;
        for (int a = 0; a < 7; a++) begin
            e = (a < 2) || (a > 4);
            @(negedge clk);
            check("full_mem_req", 32'(mem_req[0]), 32'(e));
            check("full_ignt", 32'(ignt[0]), 32'(e));
            if (e) expect_resp(0, 1'b0, ia);
            @(posedge clk); #1;
            if (e) begin ia = ia + 4; iaddr[0] = ia; end
        end
        ireq[0] = 1'b0;
        idle(6);

        // Ten back-to-back transfers through pointer wrap; last grant was fetch.
        lat[0] = 1;
        pat[0] = 2'b11; win[0] = 1'b1;
        pat[1] = 2'b11; win[1] = 1'b0;
        pat[2] = 2'b10; win[2] = 1'b0;
        pat[3] = 2'b10; win[3] = 1'b0;
        pat[4] = 2'b01; win[4] = 1'b1;
        pat[5] = 2'b11; win[5] = 1'b0;
        pat[6] = 2'b01; win[6] = 1'b1;
        pat[7] = 2'b10; win[7] = 1'b0;
        pat[8] = 2'b11; win[8] = 1'b1;
        pat[9] = 2'b11; win[9] = 1'b0;
        ia = 32'h6000; da = 32'h7000;
        iaddr[0] = ia; daddr[0] = da;
        for (int i = 0; i < 10; i++) begin
            ireq[0] = pat[i][1]; dreq[0] = pat[i][0];
            @(negedge clk);
            check("b2b_mem_req", 32'(mem_req[0]), 32'd1);
            check("b2b_ignt", 32'(ignt[0]), 32'(!win[i]));
            check("b2b_dgnt", 32'(dgnt[0]), 32'(win[i]));
            expect_resp(0, win[i], win[i] ? da : ia);
            @(posedge clk); #1;
            if (win[i]) da = da + 4;
            else        ia = ia + 4;
            iaddr[0] = ia; daddr[0] = da;
        end
        ireq[0] = 1'b0; dreq[0] = 1'b0;
        idle(2);

        // Stray response with nothing outstanding.
        force_rv[0] = 1'b1;
        @(negedge clk);
        check("stray_irvalid", 32'(irvalid[0]), 32'd0);
        check("stray_drvalid", 32'(drvalid[0]), 32'd0);
        check("stray_err_before", 32'(err[0]), 32'd0);
        @(posedge clk); #1;
        force_rv[0] = 1'b0;
        @(negedge clk);
        check("stray_err", 32'(err[0]), 32'd1);
        check("other_err", 32'(err[1]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("stray_err_sticky", 32'(err[0]), 32'd1);
        @(posedge clk); #1;

        // Reset with two transactions in flight.
        lat[0] = 4;
        ireq[0] = 1'b1; iaddr[0] = 32'h700;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("pre_rst_ignt", 32'(ignt[0]), 32'd1);
            @(posedge clk); #1;
        end
        ireq[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lat[0] = 1;
        @(negedge clk);
        check("post_rst_err", 32'(err[0]), 32'd0);
        check("post_rst_mem_req", 32'(mem_req[0]), 32'd0);
        @(posedge clk); #1;
        ireq[0] = 1'b1; dreq[0] = 1'b1;
        iaddr[0] = 32'h800; daddr[0] = 32'h900;
        @(negedge clk);
        check("post_rst_tie_ignt", 32'(ignt[0]), 32'd1);
        check("post_rst_tie_dgnt", 32'(dgnt[0]), 32'd0);
        check("post_rst_tie_addr", mem_addr[0], 32'h800);
        expect_resp(0, 1'b0, 32'h800);
        @(posedge clk); #1;
        ireq[0] = 1'b0; dreq[0] = 1'b0;
        idle(3);

        check("sb_drained_0", 32'(exp_q0.size()), 32'd0);
        check("sb_drained_1", 32'(exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
